// File: rtl/getir_paket.sv
// rtl/getir_paket.sv - shared types and constants for the instruction fetch stage
package getir_paket;

  localparam int KELIME_GENISLIK = 32;
  localparam logic [KELIME_GENISLIK-1:0] NOP_BUYRUK = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    IPTAL = 2'd2
  } durum_e;

endpackage

// File: rtl/getir_fifo.sv
// rtl/getir_fifo.sv - synchronous FIFO buffering {ps, buyruk} pairs from instruction memory
module getir_fifo #(
  parameter int GENISLIK = 64,
  parameter int DERINLIK = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [GENISLIK-1:0]       wdata,
  output logic [GENISLIK-1:0]       rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DERINLIK):0] count
);

  localparam int AW = $clog2(DERINLIK);

  logic [GENISLIK-1:0] mem [DERINLIK];
  logic [AW-1:0]       yaz_ptr;
  logic [AW-1:0]       oku_ptr;
  logic [AW:0]         sayi;
  logic                yaz;
  logic                oku;

  assign full  = (sayi == (AW+1)'(DERINLIK));
  assign empty = (sayi == '0);
  assign count = sayi;
  assign yaz   = push && !full;
  assign oku   = pop && !empty;
  assign rdata = mem[oku_ptr];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi    <= '0;
    end else if (flush) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi    <= '0;
    end else begin
      if (yaz) yaz_ptr <= yaz_ptr + AW'(1);
      if (oku) oku_ptr <= oku_ptr + AW'(1);
      case ({yaz, oku})
        2'b10:   sayi <= sayi + (AW+1)'(1);
        2'b01:   sayi <= sayi - (AW+1)'(1);
        default: sayi <= sayi;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (yaz && !flush) mem[yaz_ptr] <= wdata;
  end

endmodule

// File: rtl/getir_birimi.sv
// rtl/getir_birimi.sv - fetch PC, memory request FSM and delivery to the instruction queue
module getir_birimi
  import getir_paket::*;
#(
  parameter logic [31:0] BASLANGIC_PS  = 32'h4000_0000,
  parameter int          FIFO_DERINLIK = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        bellek_istek_o,
  output logic [31:0] bellek_adres_o,
  input  logic        bellek_gecerli_i,
  input  logic [31:0] bellek_veri_i,
  input  logic        atlama_gecerli_i,
  input  logic [31:0] atlama_ps_i,
  input  logic        durdur_i,
  input  logic        ps_durdur_i,
  output logic [31:0] buyruk_o,
  output logic [31:0] ps_o,
  output logic        kuyruk_aktif_o,
  output logic        ps_atladi_o
);

  localparam int SAYI_W = $clog2(FIFO_DERINLIK) + 1;
  localparam logic [SAYI_W-1:0] DERINLIK_SAYI = SAYI_W'(FIFO_DERINLIK);

  durum_e durum_r, durum_d;
  logic                         aktif_r;
  logic [KELIME_GENISLIK-1:0]   getir_ps_r;
  logic [KELIME_GENISLIK-1:0]   adres_r;
  logic [KELIME_GENISLIK-1:0]   atlama_ps_r;
  logic [KELIME_GENISLIK-1:0]   istek_adres;
  logic                         ps_atladi_r;
  logic                         bosluk_r;
  logic                         istek;
  logic                         fifo_push;
  logic                         fifo_dolu;
  logic                         fifo_bos;
  logic [SAYI_W-1:0]            fifo_sayi;
  logic [2*KELIME_GENISLIK-1:0] fifo_bas;
  logic                         kuyruk_aktif;

  // BOSTA issues straight from the PC; once issued the address is held in adres_r
  // so it survives a redirect while the old read drains in IPTAL.
  assign istek_adres = (durum_r == BOSTA) ? getir_ps_r : adres_r;
  assign istek       = aktif_r && ((durum_r != BOSTA) || (fifo_sayi < DERINLIK_SAYI));
  assign fifo_push   = istek && bellek_gecerli_i && (durum_r != IPTAL) &&
                       !atlama_gecerli_i && !fifo_dolu;

  assign kuyruk_aktif = !fifo_bos && !durdur_i && !atlama_gecerli_i &&
                        !ps_atladi_r && !bosluk_r;

  assign bellek_istek_o = istek;
  assign bellek_adres_o = istek ? istek_adres : '0;
  assign kuyruk_aktif_o = kuyruk_aktif;
  assign ps_atladi_o    = ps_atladi_r;
  assign ps_o           = ps_atladi_r  ? atlama_ps_r :
                          kuyruk_aktif ? fifo_bas[2*KELIME_GENISLIK-1:KELIME_GENISLIK] : '0;
  assign buyruk_o       = kuyruk_aktif ? fifo_bas[KELIME_GENISLIK-1:0] :
                          ps_atladi_r  ? NOP_BUYRUK : '0;

  always_comb begin
    durum_d = durum_r;
    case (durum_r)
      BOSTA: if (istek && !bellek_gecerli_i) durum_d = atlama_gecerli_i ? IPTAL : ISTEK;
      ISTEK: begin
        if (bellek_gecerli_i)      durum_d = BOSTA;
        else if (atlama_gecerli_i) durum_d = IPTAL;
      end
      IPTAL: if (bellek_gecerli_i) durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_r     <= BOSTA;
      aktif_r     <= 1'b0;
      getir_ps_r  <= BASLANGIC_PS;
      adres_r     <= '0;
      atlama_ps_r <= '0;
      ps_atladi_r <= 1'b0;
      bosluk_r    <= 1'b0;
    end else begin
      durum_r     <= durum_d;
      aktif_r     <= 1'b1;
      ps_atladi_r <= atlama_gecerli_i;
      bosluk_r    <= ps_durdur_i;
      if ((durum_r == BOSTA) && istek) adres_r <= getir_ps_r;
      if (atlama_gecerli_i) begin
        getir_ps_r  <= {atlama_ps_i[31:2], 2'b00};
        atlama_ps_r <= atlama_ps_i;
      end else if (fifo_push) begin
        getir_ps_r  <= getir_ps_r + 32'd4;
      end
    end
  end

  getir_fifo #(
    .GENISLIK (2*KELIME_GENISLIK),
    .DERINLIK (FIFO_DERINLIK)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (kuyruk_aktif),
    .flush (atlama_gecerli_i),
    .wdata ({istek_adres, bellek_veri_i}),
    .rdata (fifo_bas),
    .full  (fifo_dolu),
    .empty (fifo_bos),
    .count (fifo_sayi)
  );

endmodule

// File: tb/tb_getir_birimi.sv
// tb/tb_getir_birimi.sv - self-checking bench for getir_birimi
module tb_getir_birimi;

  localparam int          FIFO_D    = 2;
  localparam logic [31:0] BASLANGIC = 32'h4000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bellek_istek_o;
  logic [31:0] bellek_adres_o;
  logic        bellek_gecerli_i;
  logic [31:0] bellek_veri_i;
  logic        atlama_gecerli_i;
  logic [31:0] atlama_ps_i;
  logic        durdur_i;
  logic        ps_durdur_i;
  logic [31:0] buyruk_o;
  logic [31:0] ps_o;
  logic        kuyruk_aktif_o;
  logic        ps_atladi_o;

  always #5 clk_i = ~clk_i;

  getir_birimi #(.BASLANGIC_PS(BASLANGIC), .FIFO_DERINLIK(FIFO_D)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bellek_istek_o(bellek_istek_o), .bellek_adres_o(bellek_adres_o),
    .bellek_gecerli_i(bellek_gecerli_i), .bellek_veri_i(bellek_veri_i),
    .atlama_gecerli_i(atlama_gecerli_i), .atlama_ps_i(atlama_ps_i),
    .durdur_i(durdur_i), .ps_durdur_i(ps_durdur_i),
    .buyruk_o(buyruk_o), .ps_o(ps_o),
    .kuyruk_aktif_o(kuyruk_aktif_o), .ps_atladi_o(ps_atladi_o)
  );

  typedef struct {
    logic        atl;
    logic [31:0] hedef;
    logic        dur;
    logic        psdur;
    logic        e_istek;
    logic [31:0] e_adres;
    logic        e_aktif;
    logic [31:0] e_ps;
    logic [31:0] e_buyruk;
    logic        e_atladi;
  } vektor_t;

  vektor_t tablo [9];

  int testler = 0;
  int hatalar = 0;

  // Reference model: buffered words, one outstanding read, and pending redirect/hold flags.
  logic [63:0] m_q[$];
  bit          m_out, m_iptal, m_atladi, m_bosluk;
  logic [31:0] m_adr, m_pc, m_hedef;
  logic        e_istek, e_aktif;
  logic [31:0] e_adres, e_ps, e_buyruk;
  logic        s_atl, s_dur, s_psdur;
  logic [31:0] s_hedef;

  bit mem_aktif;
  int mem_bekle;
  int gecikme_mod;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    testler++;
    if (gercek !== beklenen) begin
      hatalar++;
      $display("FAIL %s: dut=%h beklenen=%h t=%0t", ad, gercek, beklenen, $time);
    end
  endtask

  task automatic model_sifirla();
    m_q.delete();
    m_out = 0; m_iptal = 0; m_atladi = 0; m_bosluk = 0;
    m_pc = BASLANGIC; m_hedef = '0; m_adr = '0;
    mem_aktif = 0; mem_bekle = 0;
  endtask

  task automatic girisleri_sifirla();
    atlama_gecerli_i = 0; atlama_ps_i = '0; durdur_i = 0; ps_durdur_i = 0;
    bellek_gecerli_i = 0; bellek_veri_i = '0;
  endtask

  task automatic reset_dut();
    rst_i = 0;
    girisleri_sifirla();
    @(negedge clk_i);
    rst_i = 1;
    model_sifirla();
    @(negedge clk_i);
  endtask

  task automatic adim_basla(input logic atl, input logic [31:0] hedef, input logic dur, input logic psdur);
    s_atl = atl; s_hedef = hedef; s_dur = dur; s_psdur = psdur;
    atlama_gecerli_i = atl; atlama_ps_i = hedef; durdur_i = dur; ps_durdur_i = psdur;
    if (bellek_istek_o && !mem_aktif) begin
      mem_aktif = 1;
      mem_bekle = (gecikme_mod < 0) ? int'($urandom_range(3, 0)) : gecikme_mod;
    end
    bellek_gecerli_i = bellek_istek_o && (mem_bekle == 0);
    bellek_veri_i    = bellek_adres_o + 32'd1;
    #1;
    if (!m_out && m_q.size() < FIFO_D) begin
      m_out = 1; m_iptal = 0; m_adr = m_pc;
    end
    e_istek  = m_out;
    e_adres  = m_out ? m_adr : '0;
    e_aktif  = (m_q.size() != 0) && !s_dur && !s_atl && !m_atladi && !m_bosluk;
    e_ps     = m_atladi ? m_hedef : (e_aktif ? m_q[0][63:32] : '0);
    e_buyruk = e_aktif ? m_q[0][31:0] : (m_atladi ? NOP : '0);
    kontrol("model_istek",  32'(bellek_istek_o), 32'(e_istek));
    kontrol("model_adres",  bellek_adres_o,      e_adres);
    kontrol("model_aktif",  32'(kuyruk_aktif_o), 32'(e_aktif));
    kontrol("model_ps",     ps_o,                e_ps);
    kontrol("model_buyruk", buyruk_o,            e_buyruk);
    kontrol("model_atladi", 32'(ps_atladi_o),    32'(m_atladi));
  endtask

  task automatic adim_bitir();
    bit kabul;
    kabul = m_out && bellek_gecerli_i;
    if (e_aktif) void'(m_q.pop_front());
    if (s_atl) begin
      m_q.delete();
      if (kabul) m_out = 0;
      else if (m_out) m_iptal = 1;
      m_pc = {s_hedef[31:2], 2'b00};
      m_hedef = s_hedef;
    end else if (kabul) begin
      if (!m_iptal) begin
        m_q.push_back({m_adr, m_adr + 32'd1});
        m_pc = m_pc + 32'd4;
      end
      m_out = 0;
    end
    m_atladi = s_atl;
    m_bosluk = s_psdur;
    if (bellek_gecerli_i) mem_aktif = 0;
    else if (mem_aktif && mem_bekle > 0) mem_bekle--;
    @(negedge clk_i);
  endtask

  task automatic adim(input logic atl, input logic [31:0] hedef, input logic dur, input logic psdur);
    adim_basla(atl, hedef, dur, psdur);
    adim_bitir();
  endtask

  initial begin
    logic [31:0] teslim[$];
    logic [31:0] ilk_yeni;
    bit          bulundu, yeni_var;
    int          sizinti;

    //            atl hedef          dur psd  istek adres          aktif ps             buyruk         atladi
    tablo[0] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, 32'h0,          32'h0,          1'b0};
    tablo[1] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h4000_0004, 1'b1, 32'h4000_0000, 32'h4000_0001, 1'b0};
    tablo[2] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h4000_0008, 1'b1, 32'h4000_0004, 32'h4000_0005, 1'b0};
    tablo[3] = '{1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h4000_000C, 1'b0, 32'h0,          32'h0,          1'b0};
    tablo[4] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h4000_0008, 32'h4000_0009, 1'b0};
    tablo[5] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h4000_0010, 1'b1, 32'h4000_000C, 32'h4000_000D, 1'b0};
    tablo[6] = '{1'b1, 32'h4000_0102, 1'b0, 1'b0, 1'b1, 32'h4000_0014, 1'b0, 32'h0,          32'h0,          1'b0};
    tablo[7] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h4000_0100, 1'b0, 32'h4000_0102, NOP,            1'b1};
    tablo[8] = '{1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h4000_0104, 1'b1, 32'h4000_0100, 32'h4000_0101, 1'b0};

    rst_i = 0;
    girisleri_sifirla();
    model_sifirla();
    gecikme_mod = 0;
    #12;
    kontrol("reset_istek",  32'(bellek_istek_o), 32'd0);
    kontrol("reset_adres",  bellek_adres_o,      32'd0);
    kontrol("reset_aktif",  32'(kuyruk_aktif_o), 32'd0);
    kontrol("reset_ps",     ps_o,                32'd0);
    kontrol("reset_buyruk", buyruk_o,            32'd0);
    kontrol("reset_atladi", 32'(ps_atladi_o),    32'd0);
    reset_dut();

    // Zero-wait startup, a stall cycle, then a redirect with no read outstanding
    for (int i = 0; i < 9; i++) begin
      adim_basla(tablo[i].atl, tablo[i].hedef, tablo[i].dur, tablo[i].psdur);
      kontrol($sformatf("v%0d_istek", i),  32'(bellek_istek_o), 32'(tablo[i].e_istek));
      kontrol($sformatf("v%0d_adres", i),  bellek_adres_o,      tablo[i].e_adres);
      kontrol($sformatf("v%0d_aktif", i),  32'(kuyruk_aktif_o), 32'(tablo[i].e_aktif));
      kontrol($sformatf("v%0d_ps", i),     ps_o,                tablo[i].e_ps);
      kontrol($sformatf("v%0d_buyruk", i), buyruk_o,            tablo[i].e_buyruk);
      kontrol($sformatf("v%0d_atladi", i), 32'(ps_atladi_o),    32'(tablo[i].e_atladi));
      adim_bitir();
    end

    // 3-cycle memory, stall held for 5 cycles
    gecikme_mod = 3;
    for (int i = 0; i < 5; i++) begin
      adim_basla(1'b0, 32'h0, 1'b1, 1'b0);
      kontrol("t2_durdur_aktif", 32'(kuyruk_aktif_o), 32'd0);
      if (i == 4) kontrol("t2_dolu_istek_yok", 32'(bellek_istek_o), 32'd0);
      adim_bitir();
    end
    for (int i = 0; i < 14; i++) begin
      adim_basla(1'b0, 32'h0, 1'b0, 1'b0);
      if (kuyruk_aktif_o) teslim.push_back(ps_o);
      adim_bitir();
    end
    kontrol("t2_teslim_0", (teslim.size() > 0) ? teslim[0] : 32'h0, 32'h4000_0104);
    kontrol("t2_teslim_1", (teslim.size() > 1) ? teslim[1] : 32'h0, 32'h4000_0108);
    kontrol("t2_teslim_2", (teslim.size() > 2) ? teslim[2] : 32'h0, 32'h4000_010C);

    // Redirect while the read to 0x4000_0010 is outstanding, second redirect during IPTAL
    reset_dut();
    gecikme_mod = 3;
    bulundu = 0;
    for (int i = 0; i < 60 && !bulundu; i++) begin
      if (bellek_istek_o && bellek_adres_o == 32'h4000_0010) bulundu = 1;
      else adim(1'b0, 32'h0, 1'b0, 1'b0);
    end
    kontrol("t4_istek_0x10", 32'(bulundu), 32'd1);
    adim(1'b1, 32'h4000_0200, 1'b0, 1'b0);
    adim(1'b1, 32'h4000_0300, 1'b0, 1'b0);
    sizinti = 0; yeni_var = 0; ilk_yeni = '0;
    for (int i = 0; i < 12; i++) begin
      adim_basla(1'b0, 32'h0, 1'b0, 1'b0);
      if (kuyruk_aktif_o && ps_o == 32'h4000_0010) sizinti++;
      if (!yeni_var && bellek_istek_o && bellek_adres_o != 32'h4000_0010) begin
        yeni_var = 1; ilk_yeni = bellek_adres_o;
      end
      adim_bitir();
    end
    kontrol("t4_iptal_veri_teslim", 32'(sizinti), 32'd0);
    kontrol("t4_yeni_hedef", ilk_yeni, 32'h4000_0300);

    // Hold request with two words buffered
    reset_dut();
    gecikme_mod = 0;
    adim(1'b1, 32'h4000_0400, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) adim(1'b0, 32'h0, 1'b1, 1'b0);
    adim_basla(1'b0, 32'h0, 1'b0, 1'b1);
    kontrol("t5_a_aktif", 32'(kuyruk_aktif_o), 32'd1);
    kontrol("t5_a_ps", ps_o, 32'h4000_0400);
    adim_bitir();
    adim_basla(1'b0, 32'h0, 1'b0, 1'b0);
    kontrol("t5_b_bosluk", 32'(kuyruk_aktif_o), 32'd0);
    adim_bitir();
    adim_basla(1'b0, 32'h0, 1'b0, 1'b0);
    kontrol("t5_c_aktif", 32'(kuyruk_aktif_o), 32'd1);
    kontrol("t5_c_ps", ps_o, 32'h4000_0404);
    kontrol("t5_c_buyruk", buyruk_o, 32'h4000_0405);
    adim_bitir();

    // Async reset in the middle of IPTAL
    reset_dut();
    gecikme_mod = 3;
    adim(1'b1, 32'h4000_0500, 1'b0, 1'b0);
    kontrol("t6_once_ps", ps_o, 32'h4000_0500);
    kontrol("t6_once_istek", 32'(bellek_istek_o), 32'd1);
    #2;
    rst_i = 0;
    #1;
    kontrol("t6_async_istek",  32'(bellek_istek_o), 32'd0);
    kontrol("t6_async_adres",  bellek_adres_o,      32'd0);
    kontrol("t6_async_aktif",  32'(kuyruk_aktif_o), 32'd0);
    kontrol("t6_async_ps",     ps_o,                32'd0);
    kontrol("t6_async_buyruk", buyruk_o,            32'd0);
    kontrol("t6_async_atladi", 32'(ps_atladi_o),    32'd0);
    reset_dut();
    kontrol("t6_yeniden_istek", 32'(bellek_istek_o), 32'd1);
    kontrol("t6_yeniden_adres", bellek_adres_o, BASLANGIC);

    // Randomized traffic against the model
    gecikme_mod = -1;
    for (int i = 0; i < 400; i++) begin
      adim(($urandom_range(15, 0) == 0),
           32'h4000_0000 | ($urandom & 32'h0000_0FFE),
           ($urandom_range(3, 0) == 0),
           ($urandom_range(7, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testler, hatalar);
    $finish;
  end

endmodule
